// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache storage with true-LRU ages, per-line valid/dirty,
// a combinational lookup/victim port and a flush engine that streams dirty lines out.
module dcache_sram_nway #(
    parameter int SETS   = 16,
    parameter int WAYS   = 2,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256,
    localparam int IDX_W = $clog2(SETS),
    localparam int AGE_W = $clog2(WAYS),
    localparam int CUR_W = IDX_W + AGE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              dirty_i,
    output logic              hit_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] data_o,
    output logic              victim_dirty_o,
    input  logic              flush_req_i,
    output logic              flush_busy_o,
    output logic              flush_valid_o,
    input  logic              flush_ready_i,
    output logic [IDX_W-1:0]  flush_idx_o,
    output logic [TAG_W-1:0]  flush_tag_o,
    output logic [LINE_W-1:0] flush_data_o,
    output logic              flush_done_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_OUT,
        ST_DONE
    } flush_state_e;

    flush_state_e state_q, state_d;
    logic [CUR_W-1:0] cursor_q, cursor_d;

    logic              valid_q [SETS][WAYS];
    logic              valid_d [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    logic              dirty_d [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
    logic [LINE_W-1:0] data_q  [SETS][WAYS];
    logic [LINE_W-1:0] data_d  [SETS][WAYS];
    logic [AGE_W-1:0]  age_q   [SETS][WAYS];
    logic [AGE_W-1:0]  age_d   [SETS][WAYS];

    logic              raw_hit;
    logic [AGE_W-1:0]  hit_way;
    logic              inv_found;
    logic [AGE_W-1:0]  inv_way;
    logic [AGE_W-1:0]  lru_way;
    logic [AGE_W-1:0]  victim_way;
    logic [AGE_W-1:0]  sel_way;
    logic [AGE_W-1:0]  sel_age;
    logic [IDX_W-1:0]  cur_set;
    logic [AGE_W-1:0]  cur_way;
    logic              busy;

    assign busy    = (state_q != ST_IDLE);
    assign cur_set = cursor_q[CUR_W-1:AGE_W];
    assign cur_way = cursor_q[AGE_W-1:0];

    // Descending scans so the lowest matching way index is the one kept.
    always_comb begin
        raw_hit   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i)) begin
                raw_hit = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!valid_q[addr_i][w]) begin
                inv_found = 1'b1;
                inv_way   = AGE_W'(w);
            end
            if (age_q[addr_i][w] == AGE_W'(WAYS - 1)) begin
                lru_way = AGE_W'(w);
            end
        end
        victim_way = inv_found ? inv_way : lru_way;
        sel_way    = raw_hit ? hit_way : victim_way;
        sel_age    = age_q[addr_i][sel_way];
    end

    assign hit_o          = raw_hit && !busy;
    assign tag_o          = tag_q[addr_i][sel_way];
    assign data_o         = data_q[addr_i][sel_way];
    assign victim_dirty_o = !raw_hit && valid_q[addr_i][victim_way] && dirty_q[addr_i][victim_way];

    // Array next-state: controller accesses only while the flush engine is idle.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        age_d   = age_q;
        if ((state_q == ST_IDLE) && enable_i && (raw_hit || write_i)) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == sel_way) begin
                    age_d[addr_i][w] = '0;
                end else if (age_q[addr_i][w] < sel_age) begin
                    age_d[addr_i][w] = age_q[addr_i][w] + AGE_W'(1);
                end
            end
            if (write_i) begin
                valid_d[addr_i][sel_way] = 1'b1;
                dirty_d[addr_i][sel_way] = dirty_i;
                tag_d[addr_i][sel_way]   = tag_i;
                data_d[addr_i][sel_way]  = data_i;
            end
        end
        if ((state_q == ST_OUT) && flush_ready_i) begin
            dirty_d[cur_set][cur_way] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            age_q   <= age_d;
        end
    end

    // Flush walker: the cursor is {set, way}, so an all-ones cursor is the last entry.
    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        flush_valid_o = 1'b0;
        flush_done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_req_i) begin
                    state_d  = ST_SCAN;
                    cursor_d = '0;
                end
            end
            ST_SCAN: begin
                if (valid_q[cur_set][cur_way] && dirty_q[cur_set][cur_way]) begin
                    state_d = ST_OUT;
                end else if (&cursor_q) begin
                    state_d = ST_DONE;
                end else begin
                    cursor_d = cursor_q + CUR_W'(1);
                end
            end
            ST_OUT: begin
                flush_valid_o = 1'b1;
                if (flush_ready_i) begin
                    if (&cursor_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_SCAN;
                        cursor_d = cursor_q + CUR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                flush_done_o = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cursor_q <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
        end
    end

    assign flush_busy_o = busy;
    assign flush_idx_o  = flush_valid_o ? cur_set : '0;
    assign flush_tag_o  = flush_valid_o ? tag_q[cur_set][cur_way] : '0;
    assign flush_data_o = flush_valid_o ? data_q[cur_set][cur_way] : '0;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed bench for dcache_sram_nway (4-way build): lookup, LRU replacement,
// dirty-victim reporting, flush streaming with backpressure, and reset mid-flush.
module tb_dcache_sram_nway;

    localparam int SETS   = 16;
    localparam int WAYS   = 4;
    localparam int TAG_W  = 23;
    localparam int LINE_W = 256;
    localparam int IDX_W  = 4;

    localparam logic [TAG_W-1:0] TA = 23'h0000A1;
    localparam logic [TAG_W-1:0] TB = 23'h0000B2;
    localparam logic [TAG_W-1:0] TC = 23'h0000C3;
    localparam logic [TAG_W-1:0] TD = 23'h0000D4;
    localparam logic [TAG_W-1:0] TE = 23'h0000E5;
    localparam logic [TAG_W-1:0] T1 = 23'h123456;
    localparam logic [TAG_W-1:0] T2 = 23'h223456;
    localparam logic [TAG_W-1:0] T3 = 23'h323456;
    localparam logic [TAG_W-1:0] T4 = 23'h423456;
    localparam logic [TAG_W-1:0] T5 = 23'h523456;
    localparam logic [TAG_W-1:0] TX = 23'h7ABCDE;
    localparam logic [TAG_W-1:0] TY = 23'h0F0F0F;
    localparam logic [TAG_W-1:0] TZ = 23'h5A5A5A;
    localparam logic [TAG_W-1:0] TW = 23'h3C3C3C;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              write = 1'b0;
    logic [IDX_W-1:0]  addr = '0;
    logic [TAG_W-1:0]  tag = '0;
    logic [LINE_W-1:0] data = '0;
    logic              dirty = 1'b0;
    logic              hit;
    logic [TAG_W-1:0]  tag_out;
    logic [LINE_W-1:0] data_out;
    logic              victim_dirty;
    logic              flush_req = 1'b0;
    logic              flush_busy;
    logic              flush_valid;
    logic              flush_ready = 1'b0;
    logic [IDX_W-1:0]  flush_idx;
    logic [TAG_W-1:0]  flush_tag;
    logic [LINE_W-1:0] flush_data;
    logic              flush_done;

    int vectors = 0;
    int miscompares = 0;

    dcache_sram_nway #(
        .SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .enable_i(enable), .write_i(write), .addr_i(addr), .tag_i(tag),
        .data_i(data), .dirty_i(dirty),
        .hit_o(hit), .tag_o(tag_out), .data_o(data_out), .victim_dirty_o(victim_dirty),
        .flush_req_i(flush_req), .flush_busy_o(flush_busy), .flush_valid_o(flush_valid),
        .flush_ready_i(flush_ready), .flush_idx_o(flush_idx), .flush_tag_o(flush_tag),
        .flush_data_o(flush_data), .flush_done_o(flush_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [LINE_W-1:0] mk(input logic [TAG_W-1:0] t, input logic [7:0] salt);
        return {8{salt, 1'b0, t}};
    endfunction

    task automatic chk(input string name, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic chk1(input string name, input logic obs, input logic exp);
        chk(name, LINE_W'(obs), LINE_W'(exp));
    endtask

    task automatic chkt(input string name, input logic [TAG_W-1:0] obs, input logic [TAG_W-1:0] exp);
        chk(name, LINE_W'(obs), LINE_W'(exp));
    endtask

    task automatic chkn(input string name, input int obs, input int exp);
        chk(name, LINE_W'(unsigned'(obs)), LINE_W'(unsigned'(exp)));
    endtask

    task automatic fill(input logic [IDX_W-1:0] s, input logic [TAG_W-1:0] t,
                        input logic [LINE_W-1:0] d, input logic dt);
        @(negedge clk);
        enable = 1'b1; write = 1'b1; addr = s; tag = t; data = d; dirty = dt;
        @(negedge clk);
        enable = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [IDX_W-1:0] s, input logic [TAG_W-1:0] t);
        @(negedge clk);
        enable = 1'b1; write = 1'b0; addr = s; tag = t;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic look(input logic [IDX_W-1:0] s, input logic [TAG_W-1:0] t);
        @(negedge clk);
        enable = 1'b0; write = 1'b0; addr = s; tag = t;
        #1;
    endtask

    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (flush_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic ok;
        logic seen_v;
        logic got;
        int   cnt;

        // Reset and empty-array lookup
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("rst_busy", flush_busy, 1'b0);
        chk1("rst_valid", flush_valid, 1'b0);
        chk1("rst_done", flush_done, 1'b0);
        chkt("rst_fidx_tag", flush_tag, '0);
        look(4'd3, 23'h1);
        chk1("t1_hit", hit, 1'b0);
        chk1("t1_vdirty", victim_dirty, 1'b0);
        chkt("t1_tag", tag_out, '0);
        chk("t1_data", data_out, '0);

        // LRU: fill A..D into set 5, touch A, fill E -> B evicted
        fill(4'd5, TA, mk(TA, 8'h11), 1'b0);
        fill(4'd5, TB, mk(TB, 8'h11), 1'b0);
        fill(4'd5, TC, mk(TC, 8'h11), 1'b0);
        fill(4'd5, TD, mk(TD, 8'h11), 1'b0);
        look(4'd5, TA);
        chk1("t2_hit_a", hit, 1'b1);
        chk("t2_data_a", data_out, mk(TA, 8'h11));
        look(4'd5, TD);
        chk1("t2_hit_d", hit, 1'b1);
        rd(4'd5, TA);
        look(4'd5, TE);
        chk1("t2_miss_e", hit, 1'b0);
        chkt("t2_victim_tag", tag_out, TB);
        chk("t2_victim_data", data_out, mk(TB, 8'h11));
        chk1("t2_victim_clean", victim_dirty, 1'b0);
        fill(4'd5, TE, mk(TE, 8'h11), 1'b0);
        look(4'd5, TB);
        chk1("t2_b_gone", hit, 1'b0);
        look(4'd5, TE);
        chk1("t2_hit_e", hit, 1'b1);
        chk("t2_data_e", data_out, mk(TE, 8'h11));
        look(4'd5, TA);
        chk1("t2_a_kept", hit, 1'b1);
        look(4'd5, TC);
        chk1("t2_c_kept", hit, 1'b1);

        // Write hit makes a line dirty; a conflicting fill must report it as victim
        fill(4'd2, T1, mk(T1, 8'h01), 1'b0);
        fill(4'd2, T1, mk(T1, 8'h02), 1'b1);
        look(4'd2, T1);
        chk1("t3_hit_t1", hit, 1'b1);
        chk("t3_whit_data", data_out, mk(T1, 8'h02));
        fill(4'd2, T2, mk(T2, 8'h01), 1'b0);
        fill(4'd2, T3, mk(T3, 8'h01), 1'b0);
        fill(4'd2, T4, mk(T4, 8'h01), 1'b0);
        look(4'd2, T5);
        chk1("t3_miss", hit, 1'b0);
        chk1("t3_vdirty", victim_dirty, 1'b1);
        chkt("t3_victim_tag", tag_out, T1);
        chk("t3_victim_data", data_out, mk(T1, 8'h02));
        fill(4'd2, T5, mk(T5, 8'h01), 1'b0);
        look(4'd2, T1);
        chk1("t3_t1_evicted", hit, 1'b0);
        look(4'd2, T5);
        chk1("t3_hit_t5", hit, 1'b1);

        // Flush two dirty lines with backpressure on the first
        fill(4'd1, TX, mk(TX, 8'h33), 1'b1);
        fill(4'd7, TY, mk(TY, 8'h33), 1'b0);
        fill(4'd7, TZ, mk(TZ, 8'h33), 1'b1);
        @(negedge clk);
        flush_ready = 1'b0;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        #1;
        chk1("t4_busy", flush_busy, 1'b1);
        wait_valid(ok);
        chk1("t4_first_seen", ok, 1'b1);
        chkt("t4_idx1", {19'b0, flush_idx}, 23'd1);
        chkt("t4_tag1", flush_tag, TX);
        chk("t4_data1", flush_data, mk(TX, 8'h33));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            addr = 4'd1; tag = TX;
            #1;
            chk1("t4_hit_forced0", hit, 1'b0);
            @(posedge clk);
            #1;
            chk1("t4_valid_held", flush_valid, 1'b1);
            chkt("t4_idx_held", {19'b0, flush_idx}, 23'd1);
        end
        @(negedge clk);
        flush_ready = 1'b1;
        @(negedge clk);
        flush_ready = 1'b0;
        wait_valid(ok);
        chk1("t4_second_seen", ok, 1'b1);
        chkt("t4_idx2", {19'b0, flush_idx}, 23'd7);
        chkt("t4_tag2", flush_tag, TZ);
        chk("t4_data2", flush_data, mk(TZ, 8'h33));
        @(negedge clk);
        flush_ready = 1'b1;
        cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (flush_done) cnt++;
            if (!flush_busy) begin
                got = 1'b1;
                break;
            end
        end
        flush_ready = 1'b0;
        chk1("t4_went_idle", got, 1'b1);
        chkn("t4_done_pulses", cnt, 1);
        look(4'd1, TX);
        chk1("t4_x_valid", hit, 1'b1);
        look(4'd7, TZ);
        chk1("t4_z_valid", hit, 1'b1);

        // Clean array flush: done after SETS*WAYS+1 cycles, nothing presented
        @(negedge clk);
        flush_req = 1'b1;
        cnt = 0;
        seen_v = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            flush_req = 1'b0;
            cnt++;
            if (flush_valid) seen_v = 1'b1;
            if (flush_done) begin
                got = 1'b1;
                break;
            end
        end
        chk1("t5_done_seen", got, 1'b1);
        chkn("t5_latency", cnt, SETS * WAYS + 1);
        chk1("t5_no_valid", seen_v, 1'b0);
        @(posedge clk);
        #1;
        chk1("t5_done_once", flush_done, 1'b0);
        chk1("t5_idle", flush_busy, 1'b0);

        // Reset while a line is presented
        fill(4'd3, TW, mk(TW, 8'h44), 1'b1);
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        wait_valid(ok);
        chk1("t6_out_seen", ok, 1'b1);
        chkt("t6_idx", {19'b0, flush_idx}, 23'd3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk1("t6_valid_cleared", flush_valid, 1'b0);
        chk1("t6_busy_cleared", flush_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (flush_valid || flush_done) seen_v = 1'b1;
        end
        chk1("t6_quiet", seen_v, 1'b0);
        look(4'd3, TW);
        chk1("t6_w_miss", hit, 1'b0);
        chk1("t6_vdirty", victim_dirty, 1'b0);
        chkt("t6_tag", tag_out, '0);
        look(4'd5, TA);
        chk1("t6_a_miss", hit, 1'b0);
        look(4'd7, TZ);
        chk1("t6_z_miss", hit, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
